// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive demultiplexer.
// Holds default geometry, the receiver state enum and counter-width helpers.
package tdm_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CH_W   = 8;

    localparam int DEF_BIT_CW = $clog2(DEF_CH_W);
    localparam int DEF_CH_CW  = $clog2(DEF_NUM_CH);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/channel position counters for the TDM receiver.
// Ports: i_clk, i_rst (async high), i_adv (step one bit), i_load (current bit
// is bit 0 of channel 0), i_clear (back to frame start); o_ch_cnt, o_slot_end,
// o_frame_end, o_frame_start position flags for the current bit.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_adv,
    input  logic                      i_load,
    input  logic                      i_clear,
    output logic [cnt_w(NUM_CH)-1:0]  o_ch_cnt,
    output logic                      o_slot_end,
    output logic                      o_frame_end,
    output logic                      o_frame_start
);

    localparam int BW = cnt_w(CH_W);
    localparam int CW = cnt_w(NUM_CH);

    logic [BW-1:0] r_bit_cnt;
    logic [CW-1:0] r_ch_cnt;

    logic w_slot_end;
    logic w_frame_end;

    assign w_slot_end  = (r_bit_cnt == BW'(CH_W - 1));
    assign w_frame_end = w_slot_end && (r_ch_cnt == CW'(NUM_CH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
        end else if (i_clear) begin
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
        end else if (i_load) begin
            // The bit just taken was bit 0 of channel 0.
            r_bit_cnt <= BW'(1);
            r_ch_cnt  <= '0;
        end else if (i_adv) begin
            if (w_slot_end) begin
                r_bit_cnt <= '0;
                r_ch_cnt  <= w_frame_end ? '0 : r_ch_cnt + CW'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    assign o_ch_cnt      = r_ch_cnt;
    assign o_slot_end    = w_slot_end;
    assign o_frame_end   = w_frame_end;
    assign o_frame_start = (r_bit_cnt == '0) && (r_ch_cnt == '0);

endmodule

// File: rtl/tdm_demux_rx.sv
// Time-division demultiplexer: serial TDM stream into NUM_CH parallel words.
// Ports: i_clk, i_rst (async high), i_en bit strobe, i_sdata, i_sync_in;
// o_frame_data, o_ch_valid, o_frame_valid, o_locked, o_sync_err.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_sdata,
    input  logic                     i_sync_in,
    output logic [NUM_CH*CH_W-1:0]   o_frame_data,
    output logic [NUM_CH-1:0]        o_ch_valid,
    output logic                     o_frame_valid,
    output logic                     o_locked,
    output logic                     o_sync_err
);

    localparam int CW = cnt_w(NUM_CH);

    state_t r_state;
    state_t w_state_nxt;

    logic [CH_W-1:0]        r_shift;
    logic [CH_W-1:0]        w_shift_nxt;
    logic [CH_W-1:0]        w_word;
    logic [NUM_CH*CH_W-1:0] r_frame_data;
    logic [NUM_CH-1:0]      r_ch_valid;
    logic [NUM_CH-1:0]      w_ch_valid_nxt;
    logic                   r_frame_valid;
    logic                   r_locked;
    logic                   r_sync_err;

    logic          w_adv;
    logic          w_load;
    logic          w_clear;
    logic          w_slot_wr;
    logic          w_frame_wr;
    logic          w_err;
    logic [CW-1:0] w_ch_cnt;
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_frame_start;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_cnt (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_adv         (w_adv),
        .i_load        (w_load),
        .i_clear       (w_clear),
        .o_ch_cnt      (w_ch_cnt),
        .o_slot_end    (w_slot_end),
        .o_frame_end   (w_frame_end),
        .o_frame_start (w_frame_start)
    );

    assign w_word = {r_shift[CH_W-2:0], i_sdata};

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_adv          = 1'b0;
        w_load         = 1'b0;
        w_clear        = 1'b0;
        w_slot_wr      = 1'b0;
        w_frame_wr     = 1'b0;
        w_err          = 1'b0;
        w_ch_valid_nxt = '0;
        unique case (r_state)
            HUNT: begin
                if (i_en && i_sync_in) begin
                    w_load      = 1'b1;
                    w_shift_nxt = {{(CH_W-1){1'b0}}, i_sdata};
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (i_en) begin
                    if (w_frame_start && !i_sync_in) begin
                        // Missing marker: drop this bit and re-hunt.
                        w_err       = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = HUNT;
                    end else if (i_sync_in && !w_frame_start) begin
                        // Early marker: abandon partial frame, restart here.
                        w_err       = 1'b1;
                        w_load      = 1'b1;
                        w_shift_nxt = {{(CH_W-1){1'b0}}, i_sdata};
                    end else begin
                        w_adv       = 1'b1;
                        w_shift_nxt = w_word;
                        w_slot_wr   = w_slot_end;
                        w_frame_wr  = w_frame_end;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
        if (w_slot_wr) begin
            w_ch_valid_nxt = NUM_CH'(1) << w_ch_cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_shift       <= '0;
            r_frame_data  <= '0;
            r_ch_valid    <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_ch_valid    <= w_ch_valid_nxt;
            r_frame_valid <= w_frame_wr;
            r_sync_err    <= w_err;
            if (w_slot_wr) begin
                r_frame_data[w_ch_cnt*CH_W +: CH_W] <= w_word;
            end
            if (w_err) begin
                r_locked <= 1'b0;
            end else if (w_frame_wr) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign o_frame_data  = r_frame_data;
    assign o_ch_valid    = r_ch_valid;
    assign o_frame_valid = r_frame_valid;
    assign o_locked      = r_locked;
    assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx against a position-based frame model.
// Scenario tasks drive serial frames and compare outputs inline.
module tb_tdm_demux_rx;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 8;
    localparam int FW     = NUM_CH * CH_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sdata;
    logic              sync;
    logic [FW-1:0]     o_frame_data;
    logic [NUM_CH-1:0] o_ch_valid;
    logic              o_frame_valid;
    logic              o_locked;
    logic              o_sync_err;

    tdm_demux_rx #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_sdata       (sdata),
        .i_sync_in     (sync),
        .o_frame_data  (o_frame_data),
        .o_ch_valid    (o_ch_valid),
        .o_frame_valid (o_frame_valid),
        .o_locked      (o_locked),
        .o_sync_err    (o_sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame position 0..FW-1 plus a hunting flag.
    logic [FW-1:0]     m_data;
    logic [NUM_CH-1:0] m_chv;
    logic              m_fv;
    logic              m_lock;
    logic              m_err;
    bit                m_hunt;
    int                m_pos;
    logic [CH_W-1:0]   m_acc;

    int    mis;
    string mis_txt;
    int    cyc;
    int    err_cnt;
    int    fv_cnt;
    int    pulse_cyc[$];
    logic [NUM_CH-1:0] pulse_val[$];

    task automatic model_reset();
        m_data = '0;
        m_chv  = '0;
        m_fv   = 1'b0;
        m_lock = 1'b0;
        m_err  = 1'b0;
        m_hunt = 1'b1;
        m_pos  = 0;
        m_acc  = '0;
    endtask

    task automatic clear_log();
        mis     = 0;
        mis_txt = "";
        cyc     = 0;
        err_cnt = 0;
        fv_cnt  = 0;
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    // One clock with the given inputs; the model follows the rules per bit.
    task automatic drive(input logic e, input logic d, input logic s);
        int k;
        en    = e;
        sdata = d;
        sync  = s;
        @(posedge clk);
        m_chv = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (e) begin
            if (m_hunt) begin
                if (s) begin
                    m_hunt = 1'b0;
                    m_acc  = {{(CH_W-1){1'b0}}, d};
                    m_pos  = 1;
                end
            end else if (m_pos == 0 && !s) begin
                m_err  = 1'b1;
                m_lock = 1'b0;
                m_hunt = 1'b1;
            end else begin
                if (s && m_pos != 0) begin
                    m_err  = 1'b1;
                    m_lock = 1'b0;
                    m_pos  = 0;
                end
                m_acc = {m_acc[CH_W-2:0], d};
                m_pos++;
                if (m_pos % CH_W == 0) begin
                    k = m_pos / CH_W - 1;
                    m_data[k*CH_W +: CH_W] = m_acc;
                    m_chv[k] = 1'b1;
                    if (m_pos == FW) begin
                        m_fv   = 1'b1;
                        m_lock = 1'b1;
                        m_pos  = 0;
                    end
                end
            end
        end
        #1;
        cyc++;
        if (o_ch_valid != '0) begin
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(o_ch_valid);
        end
        if (o_sync_err === 1'b1) err_cnt++;
        if (o_frame_valid === 1'b1) fv_cnt++;
        if ({o_frame_data, o_ch_valid, o_frame_valid, o_locked, o_sync_err}
            !== {m_data, m_chv, m_fv, m_lock, m_err}) begin
            if (mis == 0) begin
                mis_txt = $sformatf(
                    "cyc %0d dut %h/%b/%b/%b/%b model %h/%b/%b/%b/%b",
                    cyc, o_frame_data, o_ch_valid, o_frame_valid,
                    o_locked, o_sync_err, m_data, m_chv, m_fv,
                    m_lock, m_err);
            end
            mis++;
        end
    endtask

    // Serial frame, MSB first per slot; en high every gap-th cycle.
    task automatic send_frame(input logic [FW-1:0] w, input int gap,
                              input logic first_sync, input int spur);
        int j;
        logic b;
        logic s;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int i = 0; i < CH_W; i++) begin
                j = ch * CH_W + i;
                b = w[ch*CH_W + CH_W - 1 - i];
                s = (j == 0) ? first_sync : (j == spur);
                for (int g = 1; g < gap; g++) begin
                    drive(1'b0, 1'($urandom), 1'($urandom));
                end
                drive(1'b1, b, s);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        sdata = 1'b0;
        sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_frame_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", o_frame_data);
        end
        checks++;
        if (o_ch_valid !== '0 || o_frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0",
                     o_ch_valid, o_frame_valid);
        end
        checks++;
        if (o_locked !== 1'b0 || o_sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_lock: got %b/%b want 0/0",
                     o_locked, o_sync_err);
        end
    endtask

    task automatic test_basic();
        clear_log();
        send_frame(32'h00FF3CA5, 1, 1'b1, -1);
        checks++;
        if (o_frame_data !== 32'h00FF3CA5) begin
            errors++;
            $display("FAIL basic_data: got %h want 00ff3ca5", o_frame_data);
        end
        checks++;
        if (o_frame_valid !== 1'b1 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL basic_fv_lock: got %b/%b want 1/1",
                     o_frame_valid, o_locked);
        end
        checks++;
        if (pulse_cyc.size() !== NUM_CH) begin
            errors++;
            $display("FAIL basic_pulse_count: got %0d want %0d",
                     pulse_cyc.size(), NUM_CH);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (pulse_cyc[i] !== CH_W * (i + 1) ||
                    pulse_val[i] !== NUM_CH'(1 << i)) begin
                    errors++;
                    $display("FAIL basic_pulse%0d: got cyc %0d val %b want cyc %0d val %b",
                             i, pulse_cyc[i], pulse_val[i],
                             CH_W * (i + 1), NUM_CH'(1 << i));
                end
            end
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL basic_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(32'h44332211, 1, 1'b1, -1);
        checks++;
        if (err_cnt !== 0) begin
            errors++;
            $display("FAIL b2b_sync_err: got %0d want 0", err_cnt);
        end
        checks++;
        if (o_frame_data !== 32'h44332211 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL b2b_data: got %h lock %b want 44332211 lock 1",
                     o_frame_data, o_locked);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL b2b_model: %0d cycles differ, first %s", mis, mis_txt);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_missing_sync();
        clear_log();
        send_frame(FW'($urandom), 1, 1'b0, -1);
        checks++;
        if (err_cnt !== 1 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL miss_err: got errs %0d lock %b want 1 lock 0",
                     err_cnt, o_locked);
        end
        checks++;
        if (pulse_cyc.size() !== 0 || fv_cnt !== 0) begin
            errors++;
            $display("FAIL miss_pulses: got %0d/%0d want 0/0",
                     pulse_cyc.size(), fv_cnt);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL miss_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    task automatic test_mid_sync();
        int c0;
        logic [FW-1:0] w;
        send_frame(32'hC0FFEE11, 1, 1'b1, -1);
        clear_log();
        for (int i = 0; i < 2 * CH_W + 3; i++) begin
            drive(1'b1, 1'($urandom), i == 0);
        end
        drive(1'b1, 1'b1, 1'b1);
        c0 = cyc;
        checks++;
        if (o_sync_err !== 1'b1 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL mid_err: got err %b lock %b want 1/0",
                     o_sync_err, o_locked);
        end
        w = FW'($urandom);
        for (int i = 1; i < FW; i++) begin
            drive(1'b1, w[FW - 1 - i], 1'b0);
        end
        checks++;
        if (pulse_cyc.size() < 3 || pulse_cyc[2] !== c0 + CH_W - 1 ||
            pulse_val[2] !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ch0: got %0d pulses want ch0 at cyc %0d",
                     pulse_cyc.size(), c0 + CH_W - 1);
        end
        checks++;
        if (fv_cnt !== 1 || o_frame_valid !== 1'b1 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_fv: got %0d frames fv %b want 1 fv 1",
                     fv_cnt, o_frame_valid);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL mid_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    task automatic test_en_gaps();
        do_reset();
        clear_log();
        send_frame(32'h00FF3CA5, 3, 1'b1, -1);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (o_frame_data !== 32'h00FF3CA5 || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL gap_data: got %h want 00ff3ca5", o_frame_data);
        end
        checks++;
        if (pulse_cyc.size() !== NUM_CH || pulse_cyc[0] !== 3 * CH_W ||
            pulse_cyc[NUM_CH-1] !== 3 * FW) begin
            errors++;
            $display("FAIL gap_pulses: got %0d pulses want %0d one-cycle",
                     pulse_cyc.size(), NUM_CH);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL gap_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] w;
        clear_log();
        for (int i = 0; i < CH_W + 3; i++) begin
            drive(1'b1, 1'b1, i == 0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_frame_data, o_ch_valid, o_frame_valid, o_locked, o_sync_err}
            !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got %h/%b/%b want all 0",
                     o_frame_data, o_ch_valid, o_locked);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_log();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'($urandom), 1'b0);
        end
        checks++;
        if (pulse_cyc.size() !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL rstmid_hunt: got %0d pulses %0d errs want 0/0",
                     pulse_cyc.size(), err_cnt);
        end
        w = FW'($urandom);
        send_frame(w, 1, 1'b1, -1);
        checks++;
        if (o_frame_data !== w || o_frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_frame: got %h want %h", o_frame_data, w);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL rstmid_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    task automatic test_random();
        int mode;
        int spur;
        clear_log();
        for (int f = 0; f < 12; f++) begin
            mode = $urandom_range(0, 5);
            spur = (mode == 4) ? $urandom_range(1, FW - 1) : -1;
            send_frame(FW'($urandom), $urandom_range(1, 3), mode != 5, spur);
            if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (mis !== 0) begin
            errors++;
            $display("FAIL random_model: %0d cycles differ, first %s", mis, mis_txt);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        sdata = 1'b0;
        sync = 1'b0;
        model_reset();
        clear_log();
        test_reset();
        test_basic();
        test_back_to_back();
        test_missing_sync();
        test_mid_sync();
        test_en_gaps();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive side of the team's 4-channel select/mux path: a time-division demultiplexer.
- Takes a serial TDM bit stream on one input pin, plus a frame-sync marker.
- Distributes the bits into NUM_CH parallel channel words and flags each completed channel and frame.
- Sits between the ui_in pins and downstream channel logic in the TinyTapeout top.

Parameters:
NUM_CH, 4, number of TDM channels per frame (>=2, power of two)
CH_W, 8, bits per channel slot (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  bit strobe; sdata/sync_in are sampled only on cycles with en=1
sdata  input  1  serial TDM data, MSB first within each slot
sync_in  input  1  frame marker; high together with bit 0 (MSB) of channel 0
frame_data  output  NUM_CH*CH_W  registered channel words; channel k at bits [k*CH_W +: CH_W]
ch_valid  output  NUM_CH  one-cycle pulse per channel when its word in frame_data updates
frame_valid  output  1  one-cycle pulse when the last channel of a frame completes
locked  output  1  high while frames are arriving with correct sync
sync_err  output  1  one-cycle pulse on a sync violation

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: frame_data=0, ch_valid=0, frame_valid=0, locked=0, sync_err=0. State HUNT, counters 0, shift register 0.
- The FSM and counters advance only on en=1 cycles. en=0 holds all state; pulses are never stretched by en gaps.
- HUNT:
  - Ignore sdata until en & sync_in.
  - That bit is bit 0 of channel 0: load it, set bit_cnt=1, ch_cnt=0, go to RECV.
- RECV, bit handling:
  - Each en bit shifts into the shift register MSB-first and increments bit_cnt.
- RECV, end of channel (bit_cnt reaches CH_W-1 on an en cycle):
  - The assembled word is written into slot ch_cnt of frame_data on the next clock edge.
  - ch_valid[ch_cnt] pulses in the cycle following that en cycle.
  - bit_cnt wraps to 0 and ch_cnt increments.
- RECV, end of frame (last bit of channel NUM_CH-1):
  - frame_valid pulses in the same cycle as ch_valid[NUM_CH-1].
  - locked is set to 1 from that cycle on.
  - ch_cnt wraps to 0.
- Sync checking, at each frame-start position (bit_cnt=0, ch_cnt=0, in RECV):
  - The next en bit must carry sync_in=1. If so, continue normally.
  - If sync_in=0 there: sync_err pulse, locked cleared, go to HUNT. That bit is discarded.
- Sync at any non-start position in RECV:
  - sync_err pulse and locked cleared.
  - The partial frame is abandoned: no further ch_valid/frame_valid for it. Slots already written keep their values.
  - That bit is treated as bit 0 of channel 0; stay in RECV.
- Latency: end-of-slot en bit to ch_valid is exactly 1 clock.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). After release, the block is in HUNT.
- The first frame after HUNT produces ch_valid and frame_valid normally. locked rises with that first frame_valid.

Decomposition:
- Shared package tdm_pkg holds:
  - default NUM_CH and CH_W constants
  - the state enum (HUNT, RECV)
  - a localparam for counter widths, $clog2(CH_W) and $clog2(NUM_CH)
- Sub-module tdm_slot_counter holds the bit/channel counters. It outputs the slot_end, frame_end and frame_start position flags.
- The shift register, FSM and output registers stay in the top module.

Test Plan:
- Basic frame (NUM_CH=4, CH_W=8):
  - Stimulus: after reset, en=1 continuously; sync_in on the first bit; bytes A5,3C,FF,00.
  - Response: ch_valid pulses 0001,0010,0100,1000 at bits 8/16/24/32 +1 clk; frame_data=0x00FF3CA5; frame_valid and locked=1 with the last pulse.
- Back-to-back frames:
  - Stimulus: the frame above, then 11,22,33,44 with sync_in on its first bit.
  - Response: no sync_err; frame_data=0x44332211; locked stays 1.
- Missing sync:
  - Stimulus: after a locked frame, next frame start has sync_in=0.
  - Response: sync_err pulse; locked=0; HUNT; no ch_valid until the next sync_in.
- Mid-frame sync:
  - Stimulus: sync_in=1 on bit 3 of channel 2.
  - Response: sync_err pulse; locked=0; no frame_valid for that frame; new frame counted from that bit. Frame ch0 completes 8 en-bits later.
- en gaps:
  - Stimulus: the basic frame with en high every 3rd cycle.
  - Response: identical frame_data; each ch_valid exactly 1 cycle wide, 1 clk after the slot's last en bit.
- Reset mid-frame:
  - Stimulus: assert rst during channel 1 of a frame.
  - Response: all outputs 0 immediately, asynchronously. After release, bits without sync_in produce nothing; a full synced frame decodes correctly.
